locked_reg_bank: RTL

//  Parametrised bank of NUM_REGS write-protected registers, WIDTH bits each, all on one clock.

---
 rtl/locked_reg_bank.sv | 123 ++++++++++++
 1 files changed

// File: rtl/locked_reg_bank.sv
// Write-protected register bank: a two-word key sequence opens the bank for a bounded window.
// Optional audit outputs (viol_count, viol_addr) are enabled by defining LOCKED_REG_AUDIT_EN.
//
// state    | meaning
// LOCKED   | writes rejected, waiting for KEY0
// ARMED    | KEY0 seen, next cycle must carry KEY1 or the bank falls back to LOCKED
// UNLOCKED | writes accepted until lock_req or the timer expires
module locked_reg_bank #(
  parameter int                       WIDTH       = 8,
  parameter int                       NUM_REGS    = 4,
  parameter logic [WIDTH-1:0]         KEY0        = 8'hA5,
  parameter logic [WIDTH-1:0]         KEY1        = 8'h5A,
  parameter int                       TIMEOUT     = 16,
  parameter logic [WIDTH-1:0]         RESET_VAL   = '0,
  parameter logic [NUM_REGS-1:0]      STICKY_MASK = 4'b1000,
  localparam int                      AW          = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        key_valid,
  input  logic [WIDTH-1:0]            key_data,
  input  logic                        lock_req,
  output logic [NUM_REGS*WIDTH-1:0]   data_out,
  output logic                        unlocked,
  output logic                        wr_ack,
  output logic                        wr_err
`ifdef LOCKED_REG_AUDIT_EN
  ,
  output logic [7:0]                  viol_count,
  output logic [AW-1:0]               viol_addr
`endif
);

  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]     NUM_REGS_W = (AW + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    ARMED    = 2'd1,
    UNLOCKED = 2'd2
  } state_t;

  state_t                state;
  logic [TW-1:0]         timer;
  logic [NUM_REGS-1:0]   sticky_done;
  logic [NUM_REGS-1:0]   sticky_blk;
  logic                  addr_ok;
  logic                  accept;

  // Acceptance looks at the registered state, so the edge entering UNLOCKED still rejects.
  assign sticky_blk = STICKY_MASK & sticky_done;
  assign addr_ok    = {1'b0, wr_addr} < NUM_REGS_W;
  assign accept     = wr_en && (state == UNLOCKED) && addr_ok && !sticky_blk[wr_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOCKED;
      timer       <= '0;
      sticky_done <= '0;
      unlocked    <= 1'b0;
      wr_ack      <= 1'b0;
      wr_err      <= 1'b0;
      data_out    <= {NUM_REGS{RESET_VAL}};
    end else begin
      wr_ack <= wr_en && accept;
      wr_err <= wr_en && !accept;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (accept && (wr_addr == AW'(i))) begin
          data_out[i*WIDTH +: WIDTH] <= wr_data;
          if (STICKY_MASK[i]) sticky_done[i] <= 1'b1;
        end
      end

      case (state)
        LOCKED: begin
          if (key_valid && (key_data == KEY0)) state <= ARMED;
        end
        ARMED: begin
          if (key_valid && (key_data == KEY1)) begin
            state    <= UNLOCKED;
            unlocked <= 1'b1;
            timer    <= TW'(TIMEOUT);
          end else begin
            state <= LOCKED;
          end
        end
        UNLOCKED: begin
          if (lock_req || (timer == TW'(1))) begin
            state    <= LOCKED;
            unlocked <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state    <= LOCKED;
          unlocked <= 1'b0;
          timer    <= '0;
        end
      endcase
    end
  end

`ifdef LOCKED_REG_AUDIT_EN
  logic reject;
  assign reject = wr_en && !accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      viol_count <= '0;
      viol_addr  <= '0;
    end else if (reject) begin
      viol_addr <= wr_addr;
      if (viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
    end
  end
`endif

endmodule
